pf_ddr3_lane_dly_train_ctrl: RTL and testbench

//  Read-training sequencer for one DDR3 DQ bit's IOD input delay line.

---
 rtl/pf_ddr3_lane_dly_train_ctrl_if.sv | 32 +++
 rtl/pf_ddr3_lane_dly_train_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pf_ddr3_lane_dly_train_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pf_ddr3_lane_dly_train_ctrl_if.sv
// Lane delay-training handshake bundle: training FSM request/status plus the
// IOD delay-line, eye-monitor and RX data pins. Signal prefixes are from the
// controller's point of view (i_ = into the controller, o_ = out of it).
interface pf_ddr3_lane_dly_train_ctrl_if;
  logic       i_start;
  logic [7:0] i_rx_data;
  logic       i_eye_early;
  logic       i_eye_late;
  logic       i_dl_oor;
  logic       o_dl_move;
  logic       o_dl_direction;
  logic       o_dl_load;
  logic       o_eye_clear_flags;
  logic       o_busy;
  logic       o_done;
  logic       o_fail;
  logic [7:0] o_win_start;
  logic [7:0] o_win_end;
  logic [7:0] o_tap_final;

  modport master (
    output i_start, i_rx_data, i_eye_early, i_eye_late, i_dl_oor,
    input  o_dl_move, o_dl_direction, o_dl_load, o_eye_clear_flags,
    input  o_busy, o_done, o_fail, o_win_start, o_win_end, o_tap_final
  );

  modport slave (
    input  i_start, i_rx_data, i_eye_early, i_eye_late, i_dl_oor,
    output o_dl_move, o_dl_direction, o_dl_load, o_eye_clear_flags,
    output o_busy, o_done, o_fail, o_win_start, o_win_end, o_tap_final
  );
endinterface

// File: rtl/pf_ddr3_lane_dly_train_ctrl.sv
// Read-training sequencer for one DDR3 DQ bit's IOD input delay line.
// Sweeps the tap upward from the loaded default, scores each tap against the
// training pattern and the eye-monitor flags, keeps the longest contiguous
// passing window and then walks the delay line back to the window centre.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | waiting for start
// LOAD   | reload the default tap (tap 0)
// CLEAR  | clear the sticky early/late flags
// SETTLE | let the delay line and flags settle
// CHECK  | compare RX words with the pattern, watch flags
// EVAL   | update running/best window, pick next step
// STEP   | move the delay line up one tap
// CENTER | move down one tap until the window centre
// GAP    | spacer so decrement pulses are 2 cycles apart
// DONE_S | report success
// FAIL_S | reload default tap and report failure
module pf_ddr3_lane_dly_train_ctrl #(
  parameter int unsigned TAPS_MAX   = 128,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned SAMPLE_CYC = 16,
  parameter int unsigned MIN_WIN    = 4,
  parameter logic [7:0]  PATTERN    = 8'b01010101
) (
  input  logic                          i_fab_clk,
  input  logic                          i_arst,
  pf_ddr3_lane_dly_train_ctrl_if.slave  bus
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [8:0] LAST_TAP = 9'(TAPS_MAX - 1);
  localparam logic [8:0] MIN_LEN  = 9'(MIN_WIN);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, CHECK, EVAL, STEP, CENTER, GAP, DONE_S, FAIL_S
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_tap;
  logic             r_pass_tap;
  logic [8:0]       r_run_start;
  logic [8:0]       r_run_len;
  logic [8:0]       r_best_start;
  logic [8:0]       r_best_len;
  logic             r_done;
  logic             r_fail;
  logic [7:0]       r_win_start;
  logic [7:0]       r_win_end;
  logic [7:0]       r_tap_final;

  logic       w_move;
  logic       w_dir;
  logic       w_load;
  logic       w_clear;
  logic       w_last;
  logic       w_sample_bad;
  logic [8:0] w_run_start_eff;
  logic [8:0] w_cand_start;
  logic [8:0] w_cand_len;
  logic       w_take;
  logic [8:0] w_best_start_nxt;
  logic [8:0] w_best_len_nxt;
  logic [8:0] w_centre;

  // Window bookkeeping evaluated for the tap just checked. A pass on the last
  // tap closes the running window as if a failing tap followed it.
  always_comb begin
    w_last          = (r_tap == LAST_TAP) || bus.i_dl_oor;
    w_sample_bad    = (bus.i_rx_data != PATTERN) || bus.i_eye_early || bus.i_eye_late;
    w_run_start_eff = (r_run_len == 9'd0) ? r_tap : r_run_start;
    w_cand_len      = r_pass_tap ? (r_run_len + 9'd1) : r_run_len;
    w_cand_start    = r_pass_tap ? w_run_start_eff : r_run_start;
    w_take          = (!r_pass_tap || w_last) && (w_cand_len > r_best_len);
    w_best_len_nxt   = w_take ? w_cand_len : r_best_len;
    w_best_start_nxt = w_take ? w_cand_start : r_best_start;
    w_centre        = r_best_start + ((r_best_len - 9'd1) >> 1);
  end

  // State register.
  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and delay-line/eye-monitor pulse decode.
  always_comb begin
    w_next  = r_state;
    w_move  = 1'b0;
    w_dir   = 1'b0;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE:   if (bus.i_start) w_next = LOAD;
      LOAD:   begin w_load = 1'b1; w_next = CLEAR; end
      CLEAR:  begin w_clear = 1'b1; w_next = SETTLE; end
      SETTLE: if (r_cnt == '0) w_next = CHECK;
      CHECK:  if (r_cnt == '0) w_next = EVAL;
      EVAL: begin
        if (!w_last)                      w_next = STEP;
        else if (w_best_len_nxt >= MIN_LEN) w_next = CENTER;
        else                              w_next = FAIL_S;
      end
      STEP:   begin w_move = 1'b1; w_dir = 1'b1; w_next = CLEAR; end
      CENTER: begin
        if (r_tap > w_centre) begin
          w_move = 1'b1;
          w_next = GAP;
        end else begin
          w_next = DONE_S;
        end
      end
      GAP:    w_next = CENTER;
      DONE_S: w_next = IDLE;
      FAIL_S: begin w_load = 1'b1; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
  end

  // Timers, tap tracking, window registers and reported results.
  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cnt        <= '0;
      r_tap        <= '0;
      r_pass_tap   <= 1'b0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_win_start  <= '0;
      r_win_end    <= '0;
      r_tap_final  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_tap        <= '0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_win_start  <= '0;
            r_win_end    <= '0;
            r_tap_final  <= '0;
          end
        end
        CLEAR: r_cnt <= SETTLE_LD;
        SETTLE: begin
          if (r_cnt == '0) begin
            r_cnt      <= SAMPLE_LD;
            r_pass_tap <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CHECK: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (w_sample_bad) r_pass_tap <= 1'b0;
        end
        EVAL: begin
          if (r_pass_tap) begin
            r_run_start <= w_run_start_eff;
            r_run_len   <= r_run_len + 9'd1;
          end else begin
            r_run_len <= '0;
          end
          r_best_start <= w_best_start_nxt;
          r_best_len   <= w_best_len_nxt;
          if (w_next == FAIL_S) begin
            r_fail      <= 1'b1;
            r_tap       <= '0;
            r_win_start <= '0;
            r_win_end   <= '0;
            r_tap_final <= '0;
          end
        end
        STEP: r_tap <= r_tap + 9'd1;
        CENTER: begin
          if (r_tap > w_centre) begin
            r_tap <= r_tap - 9'd1;
          end else begin
            r_done      <= 1'b1;
            r_win_start <= r_best_start[7:0];
            r_win_end   <= 8'(r_best_start + r_best_len - 9'd1);
            r_tap_final <= r_tap[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_dl_move         = w_move;
  assign bus.o_dl_direction    = w_dir;
  assign bus.o_dl_load         = w_load;
  assign bus.o_eye_clear_flags = w_clear;
  assign bus.o_busy            = (r_state != IDLE) && (r_state != DONE_S) && (r_state != FAIL_S);
  assign bus.o_done            = r_done;
  assign bus.o_fail            = r_fail;
  assign bus.o_win_start       = r_win_start;
  assign bus.o_win_end         = r_win_end;
  assign bus.o_tap_final       = r_tap_final;

endmodule

// File: tb/tb_pf_ddr3_lane_dly_train_ctrl.sv
// Directed bench for the lane delay-training sequencer. A small IOD model
// tracks the applied tap from LOAD/MOVE pulses and presents RX data, sticky
// eye-monitor flags and the end-stop flag; expected results are hand-derived.
module tb_pf_ddr3_lane_dly_train_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pf_ddr3_lane_dly_train_ctrl_if bus ();

  pf_ddr3_lane_dly_train_ctrl #(
    .TAPS_MAX(128), .SETTLE_CYC(8), .SAMPLE_CYC(16), .MIN_WIN(4), .PATTERN(8'h55)
  ) dut (
    .i_fab_clk (clk),
    .i_arst    (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // IOD model
  logic [255:0] pass_map = '0;
  logic [7:0]   model_tap = '0;
  int           since_clear = 0;
  logic         r_early = 1'b0;
  logic         r_late  = 1'b0;
  int           early_tap = -1;
  int           late_tap  = -1;
  int           oor_tap   = -1;

  // Moves the modelled tap and raises sticky flags mid-CHECK on chosen taps.
  always @(posedge clk) begin
    if (bus.o_dl_load) model_tap <= '0;
    else if (bus.o_dl_move) model_tap <= bus.o_dl_direction ? model_tap + 8'd1 : model_tap - 8'd1;
    if (bus.o_eye_clear_flags) begin
      since_clear <= 0;
      r_early     <= 1'b0;
      r_late      <= 1'b0;
    end else begin
      since_clear <= since_clear + 1;
      if (since_clear == 12 && int'(model_tap) == early_tap) r_early <= 1'b1;
      if (since_clear == 12 && int'(model_tap) == late_tap)  r_late  <= 1'b1;
    end
  end

  assign bus.i_rx_data   = pass_map[model_tap] ? 8'h55 : (8'h55 ^ (8'h01 << model_tap[2:0]));
  assign bus.i_eye_early = r_early;
  assign bus.i_eye_late  = r_late;
  assign bus.i_dl_oor    = (int'(model_tap) == oor_tap);

  // Pulse counters and protocol watch on the delay-line pins.
  int   n_inc = 0, n_dec = 0, n_load = 0, n_clear = 0, n_viol = 0;
  logic prev_move = 1'b0;
  always @(negedge clk) begin
    if (bus.o_dl_move) begin
      if (bus.o_dl_direction) n_inc <= n_inc + 1;
      else                    n_dec <= n_dec + 1;
      if (prev_move) n_viol <= n_viol + 1;
    end
    if (bus.o_dl_load) n_load <= n_load + 1;
    if (bus.o_eye_clear_flags) n_clear <= n_clear + 1;
    if ((int'(bus.o_dl_move) + int'(bus.o_dl_load) + int'(bus.o_eye_clear_flags)) > 1) n_viol <= n_viol + 1;
    if (!bus.o_dl_move && bus.o_dl_direction) n_viol <= n_viol + 1;
    prev_move <= bus.o_dl_move;
  end

  int s_inc, s_dec, s_load, s_clear, s_viol;
  int t_cycles, t_first_move;
  bit t_timeout, t_busy1, t_done1, t_fail1, t_load1;

  task automatic snap();
    s_inc = n_inc; s_dec = n_dec; s_load = n_load; s_clear = n_clear; s_viol = n_viol;
  endtask

  task automatic set_window(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) pass_map[i] = 1'b1;
  endtask

  task automatic new_scenario();
    pass_map = '0; early_tap = -1; late_tap = -1; oor_tap = -1;
  endtask

  // Pulses START and waits (bounded) for DONE or FAIL; optionally pokes START while busy.
  task automatic run_training(input bit poke);
    @(negedge clk); bus.i_start = 1'b1;
    @(posedge clk); #1; bus.i_start = 1'b0;
    t_busy1 = bus.o_busy; t_done1 = bus.o_done; t_fail1 = bus.o_fail; t_load1 = bus.o_dl_load;
    t_cycles = 1; t_first_move = 0; t_timeout = 1'b0;
    while (!(bus.o_done || bus.o_fail)) begin
      @(posedge clk); #1; bus.i_start = 1'b0;
      t_cycles++;
      if (bus.o_dl_move && t_first_move == 0) t_first_move = t_cycles;
      if (poke && (t_cycles == 5 || t_cycles == 400 || t_cycles == 3500)) bus.i_start = 1'b1;
      if (t_cycles > 6000) begin t_timeout = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if ({bus.o_dl_move, bus.o_dl_direction, bus.o_dl_load, bus.o_eye_clear_flags, bus.o_busy, bus.o_done, bus.o_fail} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {bus.o_dl_move, bus.o_dl_direction, bus.o_dl_load, bus.o_eye_clear_flags, bus.o_busy, bus.o_done, bus.o_fail}); end
    n_checks++; if ({bus.o_win_start, bus.o_win_end, bus.o_tap_final} !== 24'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 000000", {bus.o_win_start, bus.o_win_end, bus.o_tap_final}); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({bus.o_busy, bus.o_dl_load, bus.o_dl_move} !== 3'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 000", {bus.o_busy, bus.o_dl_load, bus.o_dl_move}); end
  endtask

  task automatic test_single_window();
    new_scenario(); set_window(20, 35); snap();
    run_training(1'b0);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL single_timeout: got %0d cycles want done", t_cycles); end
    n_checks++; if ({t_busy1, t_load1, t_done1} !== 3'b110) begin n_fail++; $display("FAIL single_first_cycle busy/load/done: got %b want 110", {t_busy1, t_load1, t_done1}); end
    n_checks++; if (t_first_move !== 28) begin n_fail++; $display("FAIL single_first_move_cycle: got %0d want 28", t_first_move); end
    n_checks++; if ({bus.o_busy, bus.o_done, bus.o_fail} !== 3'b010) begin n_fail++; $display("FAIL single_status: got %b want 010", {bus.o_busy, bus.o_done, bus.o_fail}); end
    n_checks++; if (bus.o_win_start !== 8'd20) begin n_fail++; $display("FAIL single_win_start: got %0d want 20", bus.o_win_start); end
    n_checks++; if (bus.o_win_end !== 8'd35) begin n_fail++; $display("FAIL single_win_end: got %0d want 35", bus.o_win_end); end
    n_checks++; if (bus.o_tap_final !== 8'd27) begin n_fail++; $display("FAIL single_tap_final: got %0d want 27", bus.o_tap_final); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (bus.o_done !== 1'b1) begin n_fail++; $display("FAIL single_done_level: got %b want 1", bus.o_done); end
    n_checks++; if (n_inc - s_inc !== 127) begin n_fail++; $display("FAIL single_inc_moves: got %0d want 127", n_inc - s_inc); end
    n_checks++; if (n_dec - s_dec !== 100) begin n_fail++; $display("FAIL single_dec_moves: got %0d want 100", n_dec - s_dec); end
    n_checks++; if (n_load - s_load !== 1) begin n_fail++; $display("FAIL single_loads: got %0d want 1", n_load - s_load); end
    n_checks++; if (n_clear - s_clear !== 128) begin n_fail++; $display("FAIL single_clears: got %0d want 128", n_clear - s_clear); end
    n_checks++; if (model_tap !== 8'd27) begin n_fail++; $display("FAIL single_iod_tap: got %0d want 27", model_tap); end
    n_checks++; if (n_viol - s_viol !== 0) begin n_fail++; $display("FAIL single_pin_protocol: got %0d violations want 0", n_viol - s_viol); end
  endtask

  task automatic test_tie_earlier();
    new_scenario(); set_window(10, 14); set_window(40, 44); snap();
    run_training(1'b0);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL tie_timeout: got %0d cycles want done", t_cycles); end
    n_checks++; if ({bus.o_done, bus.o_fail} !== 2'b10) begin n_fail++; $display("FAIL tie_status: got %b want 10", {bus.o_done, bus.o_fail}); end
    n_checks++; if (bus.o_win_start !== 8'd10) begin n_fail++; $display("FAIL tie_win_start: got %0d want 10", bus.o_win_start); end
    n_checks++; if (bus.o_win_end !== 8'd14) begin n_fail++; $display("FAIL tie_win_end: got %0d want 14", bus.o_win_end); end
    n_checks++; if (bus.o_tap_final !== 8'd12) begin n_fail++; $display("FAIL tie_tap_final: got %0d want 12", bus.o_tap_final); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (n_dec - s_dec !== 115) begin n_fail++; $display("FAIL tie_dec_moves: got %0d want 115", n_dec - s_dec); end
    n_checks++; if (n_viol - s_viol !== 0) begin n_fail++; $display("FAIL tie_pin_protocol: got %0d violations want 0", n_viol - s_viol); end
  endtask

  task automatic test_min_window_fail();
    new_scenario(); set_window(5, 7); snap();
    run_training(1'b0);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL minwin_timeout: got %0d cycles want fail", t_cycles); end
    n_checks++; if (t_done1 !== 1'b0) begin n_fail++; $display("FAIL minwin_done_cleared_by_start: got %b want 0", t_done1); end
    n_checks++; if ({bus.o_busy, bus.o_done, bus.o_fail} !== 3'b001) begin n_fail++; $display("FAIL minwin_status: got %b want 001", {bus.o_busy, bus.o_done, bus.o_fail}); end
    n_checks++; if (bus.o_dl_load !== 1'b1) begin n_fail++; $display("FAIL minwin_final_load_with_fail: got %b want 1", bus.o_dl_load); end
    n_checks++; if ({bus.o_win_start, bus.o_win_end, bus.o_tap_final} !== 24'h0) begin n_fail++; $display("FAIL minwin_results: got %h want 000000", {bus.o_win_start, bus.o_win_end, bus.o_tap_final}); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({bus.o_done, bus.o_fail} !== 2'b01) begin n_fail++; $display("FAIL minwin_fail_level: got %b want 01", {bus.o_done, bus.o_fail}); end
    n_checks++; if (n_load - s_load !== 2) begin n_fail++; $display("FAIL minwin_loads: got %0d want 2", n_load - s_load); end
    n_checks++; if (n_inc - s_inc !== 127 || n_dec - s_dec !== 0) begin n_fail++; $display("FAIL minwin_moves inc/dec: got %0d/%0d want 127/0", n_inc - s_inc, n_dec - s_dec); end
    n_checks++; if (model_tap !== 8'd0) begin n_fail++; $display("FAIL minwin_iod_tap: got %0d want 0", model_tap); end
  endtask

  task automatic test_out_of_range();
    new_scenario(); set_window(50, 60); oor_tap = 60; snap();
    run_training(1'b0);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL oor_timeout: got %0d cycles want done", t_cycles); end
    n_checks++; if (t_fail1 !== 1'b0) begin n_fail++; $display("FAIL oor_fail_cleared_by_start: got %b want 0", t_fail1); end
    n_checks++; if ({bus.o_done, bus.o_fail} !== 2'b10) begin n_fail++; $display("FAIL oor_status: got %b want 10", {bus.o_done, bus.o_fail}); end
    n_checks++; if (bus.o_win_start !== 8'd50 || bus.o_win_end !== 8'd60) begin n_fail++; $display("FAIL oor_window: got %0d..%0d want 50..60", bus.o_win_start, bus.o_win_end); end
    n_checks++; if (bus.o_tap_final !== 8'd55) begin n_fail++; $display("FAIL oor_tap_final: got %0d want 55", bus.o_tap_final); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (n_inc - s_inc !== 60 || n_dec - s_dec !== 5) begin n_fail++; $display("FAIL oor_moves inc/dec: got %0d/%0d want 60/5", n_inc - s_inc, n_dec - s_dec); end
    n_checks++; if (n_clear - s_clear !== 61) begin n_fail++; $display("FAIL oor_clears: got %0d want 61", n_clear - s_clear); end
  endtask

  task automatic test_late_flag();
    new_scenario(); set_window(50, 60); oor_tap = 60; late_tap = 52; snap();
    run_training(1'b0);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL late_timeout: got %0d cycles want done", t_cycles); end
    n_checks++; if (bus.o_win_start !== 8'd53 || bus.o_win_end !== 8'd60) begin n_fail++; $display("FAIL late_window: got %0d..%0d want 53..60", bus.o_win_start, bus.o_win_end); end
    n_checks++; if (bus.o_tap_final !== 8'd56) begin n_fail++; $display("FAIL late_tap_final: got %0d want 56", bus.o_tap_final); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (n_dec - s_dec !== 4) begin n_fail++; $display("FAIL late_dec_moves: got %0d want 4", n_dec - s_dec); end
  endtask

  task automatic test_early_flag();
    new_scenario(); set_window(25, 40); early_tap = 30; snap();
    run_training(1'b0);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL early_timeout: got %0d cycles want done", t_cycles); end
    n_checks++; if ({bus.o_done, bus.o_fail} !== 2'b10) begin n_fail++; $display("FAIL early_status: got %b want 10", {bus.o_done, bus.o_fail}); end
    n_checks++; if (bus.o_win_start !== 8'd31 || bus.o_win_end !== 8'd40) begin n_fail++; $display("FAIL early_window: got %0d..%0d want 31..40", bus.o_win_start, bus.o_win_end); end
    n_checks++; if (bus.o_tap_final !== 8'd35) begin n_fail++; $display("FAIL early_tap_final: got %0d want 35", bus.o_tap_final); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (n_inc - s_inc !== 127 || n_dec - s_dec !== 92) begin n_fail++; $display("FAIL early_moves inc/dec: got %0d/%0d want 127/92", n_inc - s_inc, n_dec - s_dec); end
  endtask

  task automatic test_reset_abort_and_busy_start();
    int   k;
    logic busy_before;
    new_scenario(); set_window(20, 35);
    @(negedge clk); bus.i_start = 1'b1;
    @(posedge clk); #1; bus.i_start = 1'b0;
    k = 0;
    while (model_tap !== 8'd70 && k < 3000) begin @(posedge clk); #1; k++; end
    n_checks++; if (model_tap !== 8'd70) begin n_fail++; $display("FAIL abort_reach_tap70: got %0d want 70", model_tap); end
    busy_before = bus.o_busy;
    snap();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy_before !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before_reset: got %b want 1", busy_before); end
    n_checks++; if ({bus.o_dl_move, bus.o_dl_direction, bus.o_dl_load, bus.o_eye_clear_flags, bus.o_busy, bus.o_done, bus.o_fail} !== 7'b0) begin n_fail++; $display("FAIL abort_ctrl_same_cycle: got %b want 0000000", {bus.o_dl_move, bus.o_dl_direction, bus.o_dl_load, bus.o_eye_clear_flags, bus.o_busy, bus.o_done, bus.o_fail}); end
    n_checks++; if ({bus.o_win_start, bus.o_win_end, bus.o_tap_final} !== 24'h0) begin n_fail++; $display("FAIL abort_regs: got %h want 000000", {bus.o_win_start, bus.o_win_end, bus.o_tap_final}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (n_inc != s_inc || n_dec != s_dec || n_load != s_load) begin n_fail++; $display("FAIL abort_no_move_or_load: got inc/dec/load +%0d/+%0d/+%0d want 0/0/0", n_inc - s_inc, n_dec - s_dec, n_load - s_load); end
    n_checks++; if (model_tap !== 8'd70 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got tap %0d busy %b want tap 70 busy 0", model_tap, bus.o_busy); end
    snap();
    run_training(1'b1);
    n_checks++; if (t_timeout) begin n_fail++; $display("FAIL rerun_timeout: got %0d cycles want done", t_cycles); end
    n_checks++; if (bus.o_win_start !== 8'd20 || bus.o_win_end !== 8'd35) begin n_fail++; $display("FAIL rerun_window: got %0d..%0d want 20..35", bus.o_win_start, bus.o_win_end); end
    n_checks++; if (bus.o_tap_final !== 8'd27) begin n_fail++; $display("FAIL rerun_tap_final: got %0d want 27", bus.o_tap_final); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (n_load - s_load !== 1) begin n_fail++; $display("FAIL rerun_busy_start_ignored loads: got %0d want 1", n_load - s_load); end
    n_checks++; if (n_inc - s_inc !== 127 || n_dec - s_dec !== 100) begin n_fail++; $display("FAIL rerun_moves inc/dec: got %0d/%0d want 127/100", n_inc - s_inc, n_dec - s_dec); end
    n_checks++; if (model_tap !== 8'd27) begin n_fail++; $display("FAIL rerun_iod_tap: got %0d want 27", model_tap); end
  endtask

  initial begin
    bus.i_start = 1'b0;
    test_reset();
    test_single_window();
    test_tie_earlier();
    test_min_window_fail();
    test_out_of_range();
    test_late_flag();
    test_early_flag();
    test_reset_abort_and_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
